hs_ram_responder: RTL

- Responder end of the ready/strobe RAM handshake. Single-clock RAM of 2^ADDR_WIDTH x DATA_WIDTH with independent write and read channels.
- Each channel has a registered ready output, a one-cycle strobe input and a fixed completion latency.
- After every reset, a sequencer clears the array to zero.
- Sits behind any initiator that issues strobes only while the matching ready is high.

---
 rtl/hs_ram_responder.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/hs_ram_responder.sv
// rtl/hs_ram_responder.sv - ready/strobe RAM responder with power-up clear and fixed-latency channels
module hs_ram_responder #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int WRITE_LAT  = 2,
    parameter int READ_LAT   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] WriteAddr,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic                  WriteReady,
    input  logic                  read,
    input  logic [ADDR_WIDTH-1:0] ReadAddr,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  ReadReady,
    output logic                  ReadValid
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Latencies fit in four bits; a counter value of one means "completes on this edge".
    localparam logic [3:0] WR_LAT = 4'(WRITE_LAT);
    localparam logic [3:0] RD_LAT = 4'(READ_LAT);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_BUSY = 2'd2
    } chan_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] clr_ptr;
    logic                  clr_active;
    logic                  clr_last;

    chan_state_t           wr_state;
    chan_state_t           wr_state_next;
    logic [3:0]            wr_cnt;
    logic [3:0]            wr_cnt_next;
    logic                  wr_accept;
    logic                  wr_commit;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;

    chan_state_t           rd_state;
    chan_state_t           rd_state_next;
    logic [3:0]            rd_cnt;
    logic [3:0]            rd_cnt_next;
    logic                  rd_accept;
    logic                  rd_done;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  rd_bypass;

    // Both channels sit in INIT together, so the write channel state alone gates the clear sweep.
    assign clr_active = (wr_state == ST_INIT);
    assign clr_last   = (clr_ptr == LAST_ADDR);

    // A read completing on the edge that commits the same address sees the new data.
    assign rd_bypass  = wr_commit && (wr_addr_q == rd_addr_q);

    // Clear pointer walks the array once after every reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            clr_ptr <= '0;
        end else if (clr_active) begin
            clr_ptr <= clr_ptr + ADDR_ONE;
        end
    end

    // Write channel next-state: accept in IDLE, count down in BUSY, commit when the count expires.
    always_comb begin
        wr_state_next = wr_state;
        wr_cnt_next   = wr_cnt;
        wr_accept     = 1'b0;
        wr_commit     = 1'b0;
        case (wr_state)
            ST_INIT: begin
                if (clr_last) begin
                    wr_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (write) begin
                    wr_accept     = 1'b1;
                    wr_cnt_next   = WR_LAT;
                    wr_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (wr_cnt == 4'd1) begin
                    wr_commit     = 1'b1;
                    wr_state_next = ST_IDLE;
                end else begin
                    wr_cnt_next = wr_cnt - 4'd1;
                end
            end
            default: begin
                wr_state_next = ST_INIT;
            end
        endcase
    end

    // Write channel state, counter, registered ready and request capture.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_state   <= ST_INIT;
            wr_cnt     <= '0;
            WriteReady <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_state   <= wr_state_next;
            wr_cnt     <= wr_cnt_next;
            WriteReady <= (wr_state_next == ST_IDLE);
            if (wr_accept) begin
                wr_addr_q <= WriteAddr;
                wr_data_q <= WriteData;
            end
        end
    end

    // Read channel next-state: same shape as the write side, completion replaces commit.
    always_comb begin
        rd_state_next = rd_state;
        rd_cnt_next   = rd_cnt;
        rd_accept     = 1'b0;
        rd_done       = 1'b0;
        case (rd_state)
            ST_INIT: begin
                if (clr_last) begin
                    rd_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (read) begin
                    rd_accept     = 1'b1;
                    rd_cnt_next   = RD_LAT;
                    rd_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (rd_cnt == 4'd1) begin
                    rd_done       = 1'b1;
                    rd_state_next = ST_IDLE;
                end else begin
                    rd_cnt_next = rd_cnt - 4'd1;
                end
            end
            default: begin
                rd_state_next = ST_INIT;
            end
        endcase
    end

    // Read channel state, counter, registered ready/valid and returned data.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_state  <= ST_INIT;
            rd_cnt    <= '0;
            ReadReady <= 1'b0;
            ReadValid <= 1'b0;
            ReadData  <= '0;
            rd_addr_q <= '0;
        end else begin
            rd_state  <= rd_state_next;
            rd_cnt    <= rd_cnt_next;
            ReadReady <= (rd_state_next == ST_IDLE);
            ReadValid <= rd_done;
            if (rd_accept) begin
                rd_addr_q <= ReadAddr;
            end
            if (rd_done) begin
                ReadData <= rd_bypass ? wr_data_q : mem[rd_addr_q];
            end
        end
    end

    // Array port: zero fill during INIT, otherwise the pending write commit; nothing lands on a reset edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (clr_active) begin
                mem[clr_ptr] <= '0;
            end else if (wr_commit) begin
                mem[wr_addr_q] <= wr_data_q;
            end
        end
    end

endmodule
